fifo_burst_reader: RTL and testbench

//  Read-side master for the team FIFO (push/full/datain/pull/empty/dataout).
//  On a start request it drains up to burst_len words from the FIFO with pull/empty.
//  It re-presents them on a valid/ready stream toward the consumer.
//  A 2-entry skid buffer absorbs the FIFO read latency, so the stream runs at 1 word/clk.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 80 ++++++++
 rtl/fifo_burst_reader.sv | 104 ++++++++++
 tb/tb_fifo_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO burst reader and its skid buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } rd_state_e;

    localparam int SKID_DEPTH = 2;
    // Wide enough to hold occupancy 0..SKID_DEPTH.
    localparam int CREDW = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the output stream; head entry drives the stream.
// No internal latency beyond the register stage; the caller's credit logic guarantees no push when full.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int BUSW = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [BUSW-1:0]  push_dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [BUSW-1:0]  dat_o,
`ifdef FIFO_RD_PARITY_EN
    output logic             par_o,
`endif
    output logic [CREDW-1:0] occ_o
);

    logic [BUSW-1:0]  head_q, head_d;
    logic [BUSW-1:0]  tail_q, tail_d;
    logic [CREDW-1:0] occ_q, occ_d;
`ifdef FIFO_RD_PARITY_EN
    logic             par_q;
`endif

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == '0) head_d = push_dat_i;
                else             tail_d = push_dat_i;
                occ_d = occ_q + 1'b1;
            end
            2'b01: begin
                if (occ_q == CREDW'(SKID_DEPTH)) head_d = tail_q;
                occ_d = occ_q - 1'b1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever is left.
                if (occ_q == CREDW'(1)) begin
                    head_d = push_dat_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
`ifdef FIFO_RD_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
`ifdef FIFO_RD_PARITY_EN
            par_q  <= ^head_d;
`endif
        end
    end

    assign vld_o = (occ_q != '0);
    assign dat_o = head_q;
    assign occ_o = occ_q;
`ifdef FIFO_RD_PARITY_EN
    assign par_o = par_q;
`endif

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains up to burst_len words from the FIFO and replays them on a valid/ready stream at 1 word/clk.
// First beat 3 clocks after start; m_ready low stalls pulls once the skid is full. Option: FIFO_RD_PARITY_EN.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int BUSW = 32,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] burst_len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [LENW-1:0] words_out,
    output logic            pull,
    input  logic            empty,
    input  logic [BUSW-1:0] dataout,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [BUSW-1:0] m_data
`ifdef FIFO_RD_PARITY_EN
    ,
    output logic            m_parity
`endif
);

    localparam logic [CREDW:0] SKID_FULL = (CREDW + 1)'(SKID_DEPTH);

    rd_state_e        state_q;
    logic [LENW-1:0]  rem_q;
    logic [LENW-1:0]  words_q;
    logic             abort_q;
    logic             inflight_q;

    logic [CREDW-1:0] occ;
    logic [CREDW:0]   fill;
    logic             pop;
    logic             credit;
    logic             abort_l;
    logic             drain_end;

    assign pop     = m_valid & m_ready;
    assign fill    = {1'b0, occ} + {{CREDW{1'b0}}, inflight_q};
    // A pop this cycle frees the slot the word issued now will need two cycles later.
    assign credit  = (fill < SKID_FULL) | ((fill == SKID_FULL) & pop);
    assign abort_l = abort_q | abort;

    assign pull = (state_q == DRAIN) & ~empty & (rem_q != '0) & ~abort_l & credit;
    assign drain_end = ((rem_q == '0) | abort_l) & ~inflight_q & (occ == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            words_q    <= '0;
            abort_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= pull;
            if (pop && (words_q != '1)) words_q <= words_q + 1'b1;
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start) begin
                        rem_q   <= burst_len;
                        words_q <= '0;
                        state_q <= (burst_len == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) abort_q <= 1'b1;
                    if (pull)  rem_q   <= rem_q - 1'b1;
                    if (drain_end) state_q <= DONE;
                end
                DONE: begin
                    abort_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign words_out = words_q;

    fifo_rd_skid #(.BUSW(BUSW)) u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (inflight_q),
        .push_dat_i (dataout),
        .pop_i      (pop),
        .vld_o      (m_valid),
        .dat_o      (m_data),
`ifdef FIFO_RD_PARITY_EN
        .par_o      (m_parity),
`endif
        .occ_o      (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a FIFO model and an in-order scoreboard.
module tb_fifo_burst_reader;

    localparam int BUSW = 32;
    localparam int LENW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [LENW-1:0] burst_len = '0;
    logic            abort = 1'b0;
    logic            busy, done, pull, m_valid;
    logic [LENW-1:0] words_out;
    logic            empty;
    logic [BUSW-1:0] dataout = '0;
    logic            m_ready = 1'b0;
    logic [BUSW-1:0] m_data;
`ifdef FIFO_RD_PARITY_EN
    logic            m_parity;
`endif

    logic [BUSW-1:0] fmem [0:255];
    int              rd_ptr = 0;
    int              wr_ptr = 0;
    int              cyc = 0;

    logic [BUSW-1:0] exp_q[$];
    int              pull_cyc[$];
    int              beat_cyc[$];
    int              done_cyc[$];
    int              vld_cnt = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              s_cyc = 0;
    int              p0, b0, d0, v0;
    logic [BUSW-1:0] prev_dat = '0;
    logic            hold = 1'b0;
    logic [BUSW-1:0] e_dat;

    fifo_burst_reader #(.BUSW(BUSW), .LENW(LENW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .words_out (words_out),
        .pull      (pull),
        .empty     (empty),
        .dataout   (dataout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef FIFO_RD_PARITY_EN
        ,
        .m_parity  (m_parity)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after pull.
    assign empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pull) begin
            dataout <= fmem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [BUSW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[7:0]] = base + BUSW'(i);
            wr_ptr++;
        end
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic snap();
        p0 = pull_cyc.size();
        b0 = beat_cyc.size();
        d0 = done_cyc.size();
        v0 = vld_cnt;
    endtask

    task automatic kick(input int len);
        burst_len = LENW'(len);
        start     = 1'b1;
        s_cyc     = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && done_cyc.size() == d0; i++) step();
        check(tag, 32'(done_cyc.size() > d0), 32'd1);
        step();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (pull) begin
                    check("pull_while_empty", 32'(empty), 32'd0);
                    pull_cyc.push_back(cyc);
                    exp_q.push_back(fmem[rd_ptr[7:0]]);
                end
                if (m_valid) vld_cnt++;
                if (hold) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", m_data, prev_dat);
                end
                if (m_valid && m_ready) begin
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("beat_without_pull", 32'(m_valid), 32'd0);
                    end else begin
                        e_dat = exp_q.pop_front();
                        check("beat_data", m_data, e_dat);
`ifdef FIFO_RD_PARITY_EN
                        check("beat_parity", 32'(m_parity), 32'(^e_dat));
`endif
                    end
                end
                hold     = m_valid && !m_ready;
                prev_dat = m_data;
            end
            if (done) done_cyc.push_back(cyc);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset values
        #2 rst = 1'b1;
        #1;
        check("rst_pull", 32'(pull), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: burst of 4 from an 8-word FIFO, consumer always ready
        fill(8, 32'h0000_1000);
        m_ready = 1'b1;
        snap();
        kick(4);
        wait_done("t1_done");
        check("t1_pulls", 32'(pull_cyc.size() - p0), 32'd4);
        check("t1_beats", 32'(beat_cyc.size() - b0), 32'd4);
        if (pull_cyc.size() >= p0 + 4) begin
            check("t1_first_pull", 32'(pull_cyc[p0]), 32'(s_cyc + 1));
            check("t1_pull_span", 32'(pull_cyc[p0 + 3] - pull_cyc[p0]), 32'd3);
        end
        if (beat_cyc.size() >= b0 + 4) begin
            check("t1_first_beat", 32'(beat_cyc[b0]), 32'(s_cyc + 3));
            check("t1_beat_span", 32'(beat_cyc[b0 + 3] - beat_cyc[b0]), 32'd3);
        end
        check("t1_done_once", 32'(done_cyc.size() - d0), 32'd1);
        check("t1_words", 32'(words_out), 32'd4);
        check("t1_fifo_left", 32'(wr_ptr - rd_ptr), 32'd4);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: zero-length burst
        flush();
        fill(3, 32'h0000_2000);
        snap();
        kick(0);
        wait_done("t2_done");
        if (done_cyc.size() > d0) check("t2_done_cyc", 32'(done_cyc[d0]), 32'(s_cyc + 1));
        check("t2_pulls", 32'(pull_cyc.size() - p0), 32'd0);
        check("t2_valid", 32'(vld_cnt - v0), 32'd0);
        check("t2_words", 32'(words_out), 32'd0);

        // 3: consumer stalls for 10 cycles after the first beat
        flush();
        fill(6, 32'h0000_3000);
        snap();
        kick(6);
        for (int i = 0; i < 20 && beat_cyc.size() == b0; i++) step();
        m_ready = 1'b0;
        repeat (10) step();
        check("t3_stalled_pulls", 32'(pull_cyc.size() - p0), 32'd3);
        check("t3_stalled_valid", 32'(m_valid), 32'd1);
        check("t3_stalled_beats", 32'(beat_cyc.size() - b0), 32'd1);
        m_ready = 1'b1;
        wait_done("t3_done");
        check("t3_beats", 32'(beat_cyc.size() - b0), 32'd6);
        check("t3_words", 32'(words_out), 32'd6);

        // 4: FIFO runs dry mid-burst
        flush();
        fill(2, 32'h0000_4000);
        snap();
        kick(6);
        repeat (6) step();
        check("t4_gap_busy", 32'(busy), 32'd1);
        check("t4_gap_pulls", 32'(pull_cyc.size() - p0), 32'd2);
        fill(4, 32'h0000_4100);
        wait_done("t4_done");
        check("t4_pulls", 32'(pull_cyc.size() - p0), 32'd6);
        check("t4_words", 32'(words_out), 32'd6);

        // 5: abort after three pulls of a 10-word burst
        flush();
        fill(10, 32'h0000_5000);
        snap();
        kick(10);
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("t5_done");
        check("t5_pulls", 32'(pull_cyc.size() - p0), 32'd3);
        check("t5_beats", 32'(beat_cyc.size() - b0), 32'd3);
        check("t5_words", 32'(words_out), 32'd3);
        check("t5_done_once", 32'(done_cyc.size() - d0), 32'd1);

        // 6: reset in the middle of a stalled burst, then a clean burst
        flush();
        fill(6, 32'h0000_6000);
        m_ready = 1'b0;
        snap();
        kick(6);
        repeat (6) step();
        check("t6_pre_valid", 32'(m_valid), 32'd1);
        check("t6_pre_pulls", 32'(pull_cyc.size() - p0), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_pull", 32'(pull), 32'd0);
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check("t6_rst_data", m_data, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_words", 32'(words_out), 32'd0);
`ifdef FIFO_RD_PARITY_EN
        check("t6_rst_parity", 32'(m_parity), 32'd0);
`endif
        step();
        step();
        rst = 1'b0;
        step();
        flush();
        fill(3, 32'h0000_6107);
        m_ready = 1'b1;
        snap();
        kick(3);
        wait_done("t6_done");
        check("t6_beats", 32'(beat_cyc.size() - b0), 32'd3);
        check("t6_words", 32'(words_out), 32'd3);
        if (beat_cyc.size() > b0) check("t6_first_beat", 32'(beat_cyc[b0]), 32'(s_cyc + 3));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
